dmem_responder: RTL
===================

# dmem_responder

Memory-side responder for the CPU's load/store port: accepts one data request at a time over a valid/ready handshake, performs a byte/half/word store or load against an internal word-organised SRAM, and returns the response after a fixed, parameterised latency. It sits opposite the memory stage as a multi-cycle data memory model, and is the target the pipeline will stall against once memory latency exceeds one cycle.

## Interface
- `ADDR_WIDTH`, 16: byte-address bits decoded. Storage is 2^(ADDR_WIDTH-2) 32-bit words; upper address bits are ignored, so addresses wrap.
- `LATENCY`, 2: cycles from the accept edge to the first cycle `resp_valid` is high. Legal values are 1 to 15.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: responder can accept a request.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned` in 1: zero-extend loads (LBU/LHU). Ignored for word loads and for stores.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, taken from the low bits.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: consumer takes the response.
- `resp_rdata` out 32: extended load data. It is 0 for stores and on error.
- `resp_err` out 1: misaligned access or illegal size.

## Operation
- **FSM states:** IDLE, WAIT, RESP.
  - `req_ready` = (state == IDLE).
  - `resp_valid` = (state == RESP).
- **Accept:** on `req_valid && req_ready` at a rising edge:
  - capture the request;
  - compute the error;
  - perform the store, or read the SRAM word into the response register;
  - go to RESP if LATENCY == 1, otherwise load the counter with LATENCY-1 and go to WAIT.
- **WAIT:** decrement the counter each cycle. When the count reaches 1, go to RESP on the next edge.
- **RESP:** hold `resp_rdata` and `resp_err` stable. On `resp_ready`, return to IDLE. `req_valid` is ignored outside IDLE.
- **Error rule:** `resp_err` = 1 when any of these holds:
  - size is 11;
  - half access with addr[0] = 1;
  - word access with addr[1:0] != 0.
  
  On error there is no SRAM write and `resp_rdata` = 0.
- **Store:** commits on the accept edge.
  - Little-endian lanes: byte lane = addr[1:0], half lane = addr[1].
  - Only the addressed bytes change.
- **Load:** uses the word at the accept edge, selects the lane, then sign- or zero-extends to 32 bits.
- **Memory contents:** not cleared by reset. The SRAM is undefined until written; the bench preloads it through `$readmemh` or writes.

## Timing
- **Reset values** (asserted asynchronously, immediately on `rst` going low): state IDLE, `req_ready` = 1, `resp_valid` = 0, `resp_rdata` = 0, `resp_err` = 0, counter = 0.
- **Latency:** `resp_valid` rises exactly LATENCY cycles after the accept edge, and stays high until the `resp_ready` handshake edge.
- **Throughput:** at most one request per LATENCY+1 cycles; there is no accept in the handshake cycle. `req_ready` rises the cycle after the response handshake.
- **Back-to-back:** `resp_ready` held high gives RESP for exactly one cycle.
- **Backpressure:** with `resp_ready` low, RESP holds indefinitely and the outputs do not change.
- **Reset mid-operation:** the pending response is dropped and never asserted. A store already committed at its accept edge remains in the SRAM.
- **Input changes** on req_* while not in IDLE have no effect.

## Structure
- Package `dmem_pkg`: `size_t` enum (`SZ_BYTE`, `SZ_HALF`, `SZ_WORD`), `state_t` enum (IDLE/WAIT/RESP), and a `MAX_LATENCY` = 15 constant.
- Sub-module `dmem_lane_align`, combinational. It generates the misalignment flag, the 4-bit byte enables with write data shifted into its lane, and the load lane extraction with extension.
- The top module holds the FSM, counter, SRAM array and response registers.

## Test plan
- **Reset:** drive `rst` low mid-WAIT → `resp_valid` = 0 immediately. After release, `req_ready` = 1 and no response is ever produced for the dropped request.
- **Word round trip:** SW 0x10 ← 0xDEADBEEF, then LW 0x10 → `resp_rdata` = 0xDEADBEEF, `resp_err` = 0, `resp_valid` exactly 2 cycles after accept (LATENCY = 2).
- **Byte/half loads:** after the word store above:
  - LB 0x13 → 0xFFFFFFDE;
  - LBU 0x13 → 0x000000DE;
  - LH 0x12 → 0xFFFFDEAD;
  - LHU 0x12 → 0x0000DEAD;
  - LB 0x10 → 0xFFFFFFEF.
- **Byte lane store:** SB 0x11 ← 0x123456AA, then LW 0x10 → 0xDEADAAEF. SH 0x12 ← 0x0000BEEF, then LW 0x10 → 0xBEEFAAEF.
- **Errors:**
  - LW 0x12 → `resp_err` = 1, `resp_rdata` = 0;
  - SH 0x11 ← 0xFFFF, then LW 0x10 → unchanged 0xBEEFAAEF;
  - size 11 → `resp_err` = 1.
- **Backpressure:** hold `resp_ready` low 5 cycles in RESP → `resp_valid` and `resp_rdata` stable, `req_ready` = 0, and a `req_valid` pulse is ignored. Also rerun with LATENCY = 1 → response 1 cycle after accept.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder.
// Access sizes, FSM states and latency limits.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

  localparam int MAX_LATENCY = 15;
  localparam int CNT_W       = 4;

endpackage

// File: rtl/dmem_lane_align.sv
// Lane steering for stores and loads of byte/half/word accesses.
// Flags misalignment, builds byte enables and extends load data.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic        o_err,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_shift;

  assign w_shift = i_rword >> {i_addr, 3'b000};
  assign w_byte  = w_shift[7:0];
  assign w_half  = i_addr[1] ? i_rword[31:16]
                             : i_rword[15:0];

  always_comb begin
    o_err   = 1'b0;
    o_be    = 4'b0000;
    o_wdata = 32'd0;
    o_rdata = 32'd0;
    unique case (1'b1)
      (i_size == SZ_BYTE): begin
        o_be    = 4'b0001 << i_addr;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = i_unsigned ? {24'd0, w_byte}
                             : {{24{w_byte[7]}}, w_byte};
      end
      (i_size == SZ_HALF): begin
        o_err   = i_addr[0];
        o_be    = i_addr[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = i_unsigned ? {16'd0, w_half}
                             : {{16{w_half[15]}}, w_half};
      end
      (i_size == SZ_WORD): begin
        o_err   = (i_addr != 2'b00);
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = i_rword;
      end
      default: o_err = 1'b1;
    endcase
    // an erroring access must neither write nor return data
    if (o_err) begin
      o_be    = 4'b0000;
      o_rdata = 32'd0;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data memory responder for the load/store port.
// One request in flight; response after LATENCY cycles.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int IW    = ADDR_WIDTH - 2;
  localparam int DEPTH = 2 ** IW;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_rdata;
  logic               r_err;
  logic [31:0]        r_mem [DEPTH];

  logic [IW-1:0]      w_idx;
  logic [31:0]        w_rword;
  logic               w_accept;
  logic               w_err;
  logic [3:0]         w_be;
  logic [31:0]        w_wdata;
  logic [31:0]        w_ldata;

  assign w_idx    = req_addr[ADDR_WIDTH-1:2];
  assign w_rword  = r_mem[w_idx];
  assign w_accept = req_valid && (r_state == IDLE);

  dmem_lane_align u_align (
    .i_size     (req_size),
    .i_addr     (req_addr[1:0]),
    .i_unsigned (req_unsigned),
    .i_wdata    (req_wdata),
    .i_rword    (w_rword),
    .o_err      (w_err),
    .o_be       (w_be),
    .o_wdata    (w_wdata),
    .o_rdata    (w_ldata)
  );

  // storage survives reset, so it has no reset branch
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (w_accept && req_write && w_be[b])
        r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_err   <= w_err;
            r_rdata <= req_write ? 32'd0 : w_ldata;
            if (LATENCY == 1) begin
              r_state <= RESP;
            end else begin
              r_cnt   <= CNT_W'(LATENCY - 1);
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1))
            r_state <= RESP;
        end
        RESP: begin
          if (resp_ready)
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready  = (r_state == IDLE);
  assign resp_valid = (r_state == RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule
